icache: RTL
===========

# icache

Direct-mapped instruction cache between the instruction-fetch stage and the memory controller. It serves one 32-bit instruction per fetch request. On a hit it answers in one cycle from its line array. On a miss it fetches the word through a request/ready handshake with the memory controller, fills the line, and then answers. A pipeline-clear (`jump_flag`) drops any pending answer without corrupting the array.

## Interface
- `INDEX_WIDTH`, default 8: lines = 2^INDEX_WIDTH, one 32-bit word per line; tag width = 30 − INDEX_WIDTH.
- `clk` input 1: clock, all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rdy` input 1: global ready; low freezes the block.
- `pc_send_enable` input 1: fetch request valid, from the fetch stage.
- `pc_to_ic` input 32: fetch address; bits [1:0] are ignored.
- `inst_get_ready` output 1: one-cycle response pulse to the fetch stage.
- `inst_from_ic` output 32: returned instruction, valid while `inst_get_ready` is high.
- `mem_req_enable` output 1: miss request to the memory controller, held level.
- `mem_addr` output 32: miss address, word-aligned as {pc[31:2], 2'b00}.
- `mem_ready` input 1: one-cycle pulse; the requested word is on `mem_inst`.
- `mem_inst` input 32: word returned by the memory controller.
- `jump_flag` input 1: pipeline clear; abandon the current request.

## Operation
- Address split: index = pc[INDEX_WIDTH+1:2]; tag = pc[31:INDEX_WIDTH+2].
- Per line: a valid bit, a tag and a 32-bit data word. All valid bits clear on reset. Data and tag arrays are not reset.
- FSM states: IDLE, MISS, DONE.
- IDLE:
  - `pc_send_enable` high and hit (valid and tag match): drive `inst_get_ready`=1 and `inst_from_ic`=line data, then go to DONE.
  - `pc_send_enable` high and miss: drive `mem_req_enable`=1 and set `mem_addr`, latch index and tag, then go to MISS.
  - Otherwise stay in IDLE.
- MISS:
  - Hold `mem_req_enable` and `mem_addr` stable.
  - On `mem_ready`: write data, tag and valid=1 into the latched index, and drop `mem_req_enable`.
  - If not aborted: drive `inst_get_ready`=1 and `inst_from_ic`=`mem_inst`, then go to DONE.
  - If aborted: go to IDLE without responding.
- DONE:
  - `inst_get_ready` returns to 0.
  - `pc_send_enable` is ignored for this cycle, because the fetch stage still holds it high while consuming the pulse.
  - Go to IDLE.
- Abort (`jump_flag` high):
  - In IDLE or DONE: force `inst_get_ready` low, go to IDLE, start no request (jump wins over a simultaneous `pc_send_enable`).
  - In MISS: set an abort flag. The memory transaction still completes and fills the line, but no response is produced. The flag clears on the exit from MISS.
  - `jump_flag` in the same cycle as `mem_ready`: the line fills, no response is produced, go to IDLE.
- `rdy` low:
  - No state transition and no array write.
  - `inst_get_ready` is forced low; a DONE-state pulse is dropped and the FSM returns to IDLE.
  - `mem_req_enable` and `mem_addr` hold.
  - The memory controller keeps `mem_ready` low while `rdy` is low.
- A miss replaces the indexed line unconditionally; there is no write-back, because the cache is read-only.
- The memory controller does not start a new transaction in the cycle it pulses `mem_ready`, and it returns `mem_ready` only after seeing `mem_req_enable`.

## Timing
- Reset values:
  - Outputs: `inst_get_ready`=0, `inst_from_ic`=0, `mem_req_enable`=0, `mem_addr`=0.
  - Internal: state=IDLE, abort=0, all valid bits 0.
- Reset during MISS: go to IDLE with `mem_req_enable`=0. The memory controller resets in the same cycle.
- All outputs are registered.
- Hit latency: request sampled at edge E0 → `inst_get_ready` high during cycle E0–E1 → the fetch stage consumes it at E1.
- Miss latency: request sampled at E0 → `mem_req_enable` high after E0 → `mem_ready` sampled at Ek → line written and `inst_get_ready` high after Ek. Total = k+1 cycles to consumption.
- `mem_req_enable` falls in the cycle after `mem_ready` is sampled.
- `inst_get_ready` is never high for two consecutive cycles.
- Minimum spacing between responses: 2 cycles (response, DONE).

## Test plan
- Cold miss then hit:
  - Request pc=0x00001004 → `mem_req_enable`=1 with `mem_addr`=0x00001004.
  - Memory returns 0x00A00093 after 4 cycles → one-cycle `inst_get_ready` with `inst_from_ic`=0x00A00093.
  - Re-request 0x00001004 → response one cycle later, with no memory request.
- Conflict: 0x00000010 and 0x00000410 (INDEX_WIDTH=8, same index) are fetched alternately → every access misses, and each response carries that address's word.
- Jump during miss:
  - `jump_flag` pulses 2 cycles after a miss request → `mem_ready` produces no `inst_get_ready`, and the FSM returns to IDLE.
  - A later request to the same pc hits and returns the filled word.
- Jump together with a hit request in IDLE → no response and no memory request; the next request is served normally.
- `rdy` stall: drop `rdy` for 3 cycles in MISS → `mem_req_enable` and `mem_addr` hold, and nothing is written. After `rdy` rises, `mem_ready` completes the fill and response normally.
- Reset mid-MISS → `mem_req_enable`=0 the next cycle; after reset, the earlier-filled 0x00001004 misses again because valid was cleared.

Source files
------------

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache, plus global rdy/jump.
// slave = cache side, master = fetch stage / memory controller side.
interface icache_if;
  logic        rdy;
  logic        pc_send_enable;
  logic [31:0] pc_to_ic;
  logic        jump_flag;
  logic        inst_get_ready;
  logic [31:0] inst_from_ic;
  logic        mem_req_enable;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_inst;

  modport slave (
    input  rdy, pc_send_enable, pc_to_ic, jump_flag, mem_ready, mem_inst,
    output inst_get_ready, inst_from_ic, mem_req_enable, mem_addr
  );

  modport master (
    output rdy, pc_send_enable, pc_to_ic, jump_flag, mem_ready, mem_inst,
    input  inst_get_ready, inst_from_ic, mem_req_enable, mem_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache: hit answers 1 cycle after the request,
// miss answers the cycle after mem_ready; rdy low freezes state and suppresses responses.
module icache #(
  parameter int INDEX_WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  icache_if.slave  bus
);
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = 30 - INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, MISS, DONE} state_e;

  state_e                 state_q, state_d;
  logic                   abort_q, abort_d;
  logic                   inst_get_ready_q, inst_get_ready_d;
  logic [31:0]            inst_from_ic_q, inst_from_ic_d;
  logic                   mem_req_enable_q, mem_req_enable_d;
  logic [31:0]            mem_addr_q, mem_addr_d;
  logic [INDEX_WIDTH-1:0] miss_idx_q, miss_idx_d;
  logic [TAG_W-1:0]       miss_tag_q, miss_tag_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic                   fill_we;

  logic [TAG_W-1:0]       tag_mem  [LINES];
  logic [31:0]            data_mem [LINES];

  logic [INDEX_WIDTH-1:0] req_idx;
  logic [TAG_W-1:0]       req_tag;
  logic                   lookup_hit;
  logic                   req_go;
  logic                   aborted;
  logic                   unused_pc_bits;

  assign req_idx        = bus.pc_to_ic[INDEX_WIDTH+1:2];
  assign req_tag        = bus.pc_to_ic[31:INDEX_WIDTH+2];
  assign lookup_hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  // jump beats a simultaneous fetch request
  assign req_go         = bus.pc_send_enable && !bus.jump_flag;
  assign aborted        = abort_q || bus.jump_flag;
  assign unused_pc_bits = ^bus.pc_to_ic[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!bus.rdy) begin
      if (state_q == DONE) state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (req_go) state_d = lookup_hit ? DONE : MISS;
        MISS:    if (bus.mem_ready) state_d = aborted ? IDLE : DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    inst_get_ready_d = 1'b0;
    inst_from_ic_d   = inst_from_ic_q;
    mem_req_enable_d = mem_req_enable_q;
    mem_addr_d       = mem_addr_q;
    miss_idx_d       = miss_idx_q;
    miss_tag_d       = miss_tag_q;
    abort_d          = abort_q;
    valid_d          = valid_q;
    fill_we          = 1'b0;
    if (bus.rdy) begin
      case (state_q)
        IDLE: begin
          if (req_go && lookup_hit) begin
            inst_get_ready_d = 1'b1;
            inst_from_ic_d   = data_mem[req_idx];
          end else if (req_go) begin
            mem_req_enable_d = 1'b1;
            mem_addr_d       = {bus.pc_to_ic[31:2], 2'b00};
            miss_idx_d       = req_idx;
            miss_tag_d       = req_tag;
          end
        end
        MISS: begin
          abort_d = aborted;
          // the fill always lands, even when the answer is abandoned
          if (bus.mem_ready) begin
            fill_we             = 1'b1;
            valid_d[miss_idx_q] = 1'b1;
            mem_req_enable_d    = 1'b0;
            abort_d             = 1'b0;
            if (!aborted) begin
              inst_get_ready_d = 1'b1;
              inst_from_ic_d   = bus.mem_inst;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      abort_q          <= 1'b0;
      inst_get_ready_q <= 1'b0;
      inst_from_ic_q   <= 32'h0;
      mem_req_enable_q <= 1'b0;
      mem_addr_q       <= 32'h0;
      miss_idx_q       <= '0;
      miss_tag_q       <= '0;
      valid_q          <= '0;
    end else begin
      abort_q          <= abort_d;
      inst_get_ready_q <= inst_get_ready_d;
      inst_from_ic_q   <= inst_from_ic_d;
      mem_req_enable_q <= mem_req_enable_d;
      mem_addr_q       <= mem_addr_d;
      miss_idx_q       <= miss_idx_d;
      miss_tag_q       <= miss_tag_d;
      valid_q          <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[miss_idx_q]  <= miss_tag_q;
      data_mem[miss_idx_q] <= bus.mem_inst;
    end
  end

  assign bus.inst_get_ready = inst_get_ready_q;
  assign bus.inst_from_ic   = inst_from_ic_q;
  assign bus.mem_req_enable = mem_req_enable_q;
  assign bus.mem_addr       = mem_addr_q;
endmodule
